// File: rtl/logs_sweep_ctrl_pkg.sv
// Shared types and FRAC-derived widths for the logistic-map r-sweep controller
// and the iterator it drives.
package logs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESTART,
        WARM,
        EMIT,
        STEP,
        FIN
    } state_t;

    localparam int unsigned LOGS_FRAC = 4;
    localparam int unsigned LOGS_R_W  = LOGS_FRAC + 2;
    localparam int unsigned LOGS_X_W  = LOGS_FRAC;

    // Counter width able to hold max(a,b) without wrapping; never zero.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/logs_sweep_ctrl_if.sv
// Iterator handshake and sample stream between the sweep controller (master)
// and its consumers (slave).
interface logs_sweep_ctrl_if #(
    parameter int unsigned FRAC = logs_pkg::LOGS_FRAC
);

    logic            next_ready;
    logic [FRAC-1:0] x_in;
    logic [FRAC+1:0] r_out;
    logic            iter_reset;
    logic            sample_valid;
    logic [FRAC+1:0] sample_r;
    logic [FRAC-1:0] sample_x;

    modport master (
        input  next_ready, x_in,
        output r_out, iter_reset, sample_valid, sample_r, sample_x
    );

    modport slave (
        output next_ready, x_in,
        input  r_out, iter_reset, sample_valid, sample_r, sample_x
    );

endinterface

// File: rtl/logs_sweep_ctrl.sv
// Sweeps r across [R_START, R_END], discarding WARMUP iterator outputs and emitting
// SAMPLES (r, x) points per step. Define LOGS_SWEEP_LOOP_EN for a repeating sweep.
module logs_sweep_ctrl
    import logs_pkg::*;
#(
    parameter int unsigned     FRAC    = LOGS_FRAC,
    parameter int unsigned     WARMUP  = 16,
    parameter int unsigned     SAMPLES = 8,
    parameter logic [FRAC+1:0] R_START = (FRAC+2)'(2 << FRAC),
    parameter logic [FRAC+1:0] R_STEP  = (FRAC+2)'((1 << FRAC) >> 4),
    parameter logic [FRAC+1:0] R_END   = (FRAC+2)'((63 << FRAC) >> 4)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    logs_sweep_ctrl_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W      = cnt_width(WARMUP, SAMPLES);
    localparam logic [CNT_W-1:0] WARM_LAST  = (WARMUP  > 0) ? CNT_W'(WARMUP - 1)  : '0;
    localparam logic [CNT_W-1:0] SAMP_LAST  = (SAMPLES > 0) ? CNT_W'(SAMPLES - 1) : '0;
    localparam state_t           AFTER_WARM = (SAMPLES > 0) ? EMIT : STEP;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [FRAC+2:0]  sum;
    logic             advance;
    logic             warm_hit;
    logic             samp_hit;
`ifdef LOGS_SWEEP_LOOP_EN
    logic             stop_req;
`endif

    // Extra sum bit catches the carry out of the 2.FRAC range.
    always_comb begin
        sum      = {1'b0, bus.r_out} + {1'b0, R_STEP};
        advance  = !sum[FRAC+2] && (sum[FRAC+1:0] <= R_END);
        warm_hit = bus.next_ready && (cnt == WARM_LAST);
        samp_hit = bus.next_ready && (cnt == SAMP_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RESTART;
            RESTART: state_nxt = (WARMUP == 0) ? AFTER_WARM : WARM;
            WARM:    if (warm_hit) state_nxt = AFTER_WARM;
            EMIT:    if (samp_hit) state_nxt = STEP;
`ifdef LOGS_SWEEP_LOOP_EN
            STEP:    state_nxt = stop_req ? FIN : RESTART;
`else
            STEP:    state_nxt = advance ? RESTART : FIN;
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.iter_reset = (state == IDLE) || (state == RESTART);
        busy           = (state != IDLE);
`ifdef LOGS_SWEEP_LOOP_EN
        done           = (state == FIN) || ((state == STEP) && !advance && !stop_req);
`else
        done           = (state == FIN);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.r_out        <= R_START;
            bus.sample_valid <= 1'b0;
            bus.sample_r     <= '0;
            bus.sample_x     <= '0;
            cnt              <= '0;
`ifdef LOGS_SWEEP_LOOP_EN
            stop_req         <= 1'b0;
`endif
        end else begin
            bus.sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) bus.r_out <= R_START;
                end
                RESTART: cnt <= '0;
                WARM: begin
                    if (bus.next_ready) cnt <= warm_hit ? '0 : cnt + 1'b1;
                end
                EMIT: begin
                    if (bus.next_ready) begin
                        bus.sample_x     <= bus.x_in;
                        bus.sample_r     <= bus.r_out;
                        bus.sample_valid <= 1'b1;
                        cnt              <= samp_hit ? '0 : cnt + 1'b1;
                    end
                end
                STEP: begin
`ifdef LOGS_SWEEP_LOOP_EN
                    if (!stop_req) bus.r_out <= advance ? sum[FRAC+1:0] : R_START;
`else
                    if (advance) bus.r_out <= sum[FRAC+1:0];
`endif
                end
                default: ;
            endcase
`ifdef LOGS_SWEEP_LOOP_EN
            // A start while running latches a stop request for the next STEP.
            if (state == IDLE)  stop_req <= 1'b0;
            else if (start)     stop_req <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_logs_sweep_ctrl.sv
// Randomised-iterator bench for logs_sweep_ctrl: two instances (normal and overflow
// start point) checked against a point-list / warm-up-window reference model.
module tb_logs_sweep_ctrl;

    localparam int unsigned W       = 2;
    localparam int unsigned S       = 3;
    localparam logic [5:0]  START_A = 6'h20;
    localparam logic [5:0]  START_B = 6'h3C;
    localparam logic [5:0]  STEP_V  = 6'h08;
    localparam logic [5:0]  END_V   = 6'h3F;

    typedef struct {
        int unsigned dut;
        logic [3:0]  x;
        int unsigned due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start;
    logic [1:0] busy;
    logic [1:0] done;
    logic       next_ready;
    logic [3:0] x_in;

    logic [1:0] sv;
    logic [1:0] ir;
    logic [5:0] sr [2];
    logic [5:0] ro [2];
    logic [3:0] sx [2];

    always #5 clk = ~clk;

    logs_sweep_ctrl_if #(.FRAC(4)) bus_a ();
    logs_sweep_ctrl_if #(.FRAC(4)) bus_b ();

    assign bus_a.next_ready = next_ready;
    assign bus_a.x_in       = x_in;
    assign bus_b.next_ready = next_ready;
    assign bus_b.x_in       = x_in;

    assign sv[0] = bus_a.sample_valid;
    assign sv[1] = bus_b.sample_valid;
    assign ir[0] = bus_a.iter_reset;
    assign ir[1] = bus_b.iter_reset;
    assign sr[0] = bus_a.sample_r;
    assign sr[1] = bus_b.sample_r;
    assign ro[0] = bus_a.r_out;
    assign ro[1] = bus_b.r_out;
    assign sx[0] = bus_a.sample_x;
    assign sx[1] = bus_b.sample_x;

    logs_sweep_ctrl #(
        .FRAC(4), .WARMUP(W), .SAMPLES(S),
        .R_START(START_A), .R_STEP(STEP_V), .R_END(END_V)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start[0]),
        .bus(bus_a.master), .busy(busy[0]), .done(done[0])
    );

    logs_sweep_ctrl #(
        .FRAC(4), .WARMUP(W), .SAMPLES(S),
        .R_START(START_B), .R_STEP(STEP_V), .R_END(END_V)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start[1]),
        .bus(bus_b.master), .busy(busy[1]), .done(done[1])
    );

    int unsigned tests;
    int unsigned fails;
    int unsigned cyc;
    int unsigned nsamp [2];
    int unsigned ndone [2];
    int unsigned seg   [2];
    int unsigned base  [2];
    int unsigned pts   [2][64];
    int unsigned npts  [2];
    logic [1:0]  start_req;
    exp_t        exp_q [$];
    bit          loop_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // r points visited by one sweep, from plain integer arithmetic.
    task automatic build_points(input int unsigned d, input int unsigned r0);
        int unsigned r;
        int unsigned nxt;
        r       = r0;
        npts[d] = 0;
        forever begin
            pts[d][npts[d]] = r;
            npts[d]++;
            nxt = r + STEP_V;
            if (nxt > 63 || nxt > END_V || npts[d] >= 64) break;
            r = nxt;
        end
    endtask

    function automatic int find_exp(input int unsigned d);
        foreach (exp_q[i]) if (exp_q[i].dut == d) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_r(input int unsigned d);
        int unsigned k;
        k = (nsamp[d] - base[d]) / S;
        if (loop_mode)    return pts[d][k % npts[d]];
        if (k < npts[d])  return pts[d][k];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic observe();
        int          idx;
        bit          expect_v;
        logic [31:0] rv;
        for (int unsigned d = 0; d < 2; d++) begin
            idx      = find_exp(d);
            expect_v = (idx >= 0) && (exp_q[idx].due == cyc);
            chk(d == 0 ? "a_sample_valid" : "b_sample_valid", {31'd0, sv[d]}, {31'd0, expect_v});
            if (expect_v) begin
                if (sv[d]) begin
                    rv = exp_r(d);
                    chk(d == 0 ? "a_sample_x" : "b_sample_x", {28'd0, sx[d]}, {28'd0, exp_q[idx].x});
                    chk(d == 0 ? "a_sample_r" : "b_sample_r", {26'd0, sr[d]}, rv);
                end
                exp_q.delete(idx);
            end
            if (sv[d])   nsamp[d]++;
            if (done[d]) ndone[d]++;
            // Window model: pulses W+1..W+S after iter_reset falls each yield a sample next cycle.
            if (reset || ir[d]) begin
                seg[d] = 0;
            end else if (next_ready) begin
                seg[d]++;
                if (seg[d] > W && seg[d] <= W + S) exp_q.push_back('{d, x_in, cyc + 1});
            end
        end
        if (reset) exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start      = start_req;
        start_req  = '0;
        next_ready = ($urandom_range(0, 3) != 0);
        x_in       = 4'($urandom);
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic check_reset_vals(input int unsigned d);
        chk("rst_iter_reset", {31'd0, ir[d]}, 32'd1);
        chk("rst_r_out", {26'd0, ro[d]}, (d == 0) ? {26'd0, START_A} : {26'd0, START_B});
        chk("rst_sample_valid", {31'd0, sv[d]}, 32'd0);
        chk("rst_sample_r", {26'd0, sr[d]}, 32'd0);
        chk("rst_sample_x", {28'd0, sx[d]}, 32'd0);
        chk("rst_busy", {31'd0, busy[d]}, 32'd0);
        chk("rst_done", {31'd0, done[d]}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned dn [2];
        int unsigned at_stop [2];
        int unsigned lat;
        int unsigned p;
        bit          injected;
        bit          finished;

        tests = 0; fails = 0; cyc = 0;
        start = '0; start_req = '0; next_ready = 1'b0; x_in = '0;
        loop_mode = 1'b0;
`ifdef LOGS_SWEEP_LOOP_EN
        loop_mode = 1'b1;
`endif
        for (int unsigned d = 0; d < 2; d++) begin
            nsamp[d] = 0; ndone[d] = 0; seg[d] = 0; base[d] = 0;
        end
        build_points(0, START_A);
        build_points(1, START_B);

        reset = 1'b1;
        #3;
        check_reset_vals(0);
        check_reset_vals(1);
        tick();
        tick();
        reset = 1'b0;
        tick();

`ifndef LOGS_SWEEP_LOOP_EN
        // Single sweep on A, overflow point on B, plus a start pulse into A mid-sweep.
        base[0] = nsamp[0]; base[1] = nsamp[1];
        dn[0] = ndone[0]; dn[1] = ndone[1];
        start_req = 2'b11;
        tick();
        n = 0; injected = 1'b0; finished = 1'b0;
        while (!finished && n < 3000) begin
            if (!injected && (nsamp[0] - base[0]) >= 4) begin
                start_req[0] = 1'b1;
                injected     = 1'b1;
            end
            tick();
            n++;
            finished = (ndone[0] != dn[0]) && (ndone[1] != dn[1]) && (busy == 2'b00);
        end
        chk("sweep_finished", {31'd0, finished}, 32'd1);
        chk("a_sample_count", nsamp[0] - base[0], 32'd12);
        chk("b_sample_count", nsamp[1] - base[1], 32'd3);
        chk("a_done_count", ndone[0] - dn[0], 32'd1);
        chk("b_done_count", ndone[1] - dn[1], 32'd1);
        chk("a_r_hold", {26'd0, ro[0]}, 32'h38);
        chk("b_r_hold", {26'd0, ro[1]}, 32'h3C);
        chk("iter_reset_idle", {30'd0, ir}, 32'd3);
`else
        // Repeating sweep on both, stopped by a start pulse once A has wrapped twice.
        base[0] = nsamp[0]; base[1] = nsamp[1];
        dn[0] = ndone[0]; dn[1] = ndone[1];
        start_req = 2'b11;
        tick();
        n = 0;
        while ((ndone[0] - dn[0]) < 2 && n < 3000) begin
            tick();
            n++;
        end
        chk("loop_two_passes", {31'd0, ((ndone[0] - dn[0]) >= 2)}, 32'd1);
        at_stop[0] = nsamp[0] - base[0];
        at_stop[1] = nsamp[1] - base[1];
        start_req = 2'b11;
        tick();
        n = 0; finished = 1'b0;
        while (!finished && n < 3000) begin
            tick();
            n++;
            finished = (busy == 2'b00);
        end
        chk("loop_stopped", {31'd0, finished}, 32'd1);
        for (int unsigned d = 0; d < 2; d++) begin
            lat = (nsamp[d] - base[d]) - at_stop[d];
            p   = (nsamp[d] - base[d]) / S;
            chk("loop_whole_points", (nsamp[d] - base[d]) % S, 32'd0);
            chk("loop_stop_latency", {31'd0, (lat >= 1 && lat <= 2 * S)}, 32'd1);
            chk("loop_done_count", ndone[d] - dn[d], (p - 1) / npts[d] + 1);
        end
`endif

        // Abort A after its fifth sample with an asynchronous reset.
        base[0] = nsamp[0]; base[1] = nsamp[1];
        dn[0] = ndone[0]; dn[1] = ndone[1];
        start_req = 2'b01;
        tick();
        n = 0;
        while ((nsamp[0] - base[0]) < 5 && n < 3000) begin
            tick();
            n++;
        end
        chk("abort_reached_5", nsamp[0] - base[0], 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(0);
        check_reset_vals(1);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        base[0] = nsamp[0]; base[1] = nsamp[1];
        for (int unsigned i = 0; i < 40; i++) tick();
        chk("abort_no_done", ndone[0] - dn[0], 32'd0);
        chk("abort_no_samples", nsamp[0] - base[0], 32'd0);
        chk("abort_idle", {30'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
